// File: rtl/dist_ram_dp_sync_if.sv
// Port bundle for dist_ram_dp_sync.
//   a/d/we/be          : port A address, write data, write enable, byte enables
//   dpra               : port B read address
//   qspo_ce/qspo_srst  : port A output register clock enable / sync reset
//   qdpo_ce/qdpo_srst  : port B output register clock enable / sync reset
//   qspo/qdpo          : registered read data, ports A and B
//   busy               : clear sweep in progress
// master drives requests (core side), slave is the RAM.
interface dist_ram_dp_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   a;
  logic [DATA_WIDTH-1:0]   d;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   dpra;
  logic                    qspo_ce;
  logic                    qspo_srst;
  logic                    qdpo_ce;
  logic                    qdpo_srst;
  logic [DATA_WIDTH-1:0]   qspo;
  logic [DATA_WIDTH-1:0]   qdpo;
  logic                    busy;

  modport master (
    output a, d, we, be, dpra, qspo_ce, qspo_srst, qdpo_ce, qdpo_srst,
    input  qspo, qdpo, busy
  );

  modport slave (
    input  a, d, we, be, dpra, qspo_ce, qspo_srst, qdpo_ce, qdpo_srst,
    output qspo, qdpo, busy
  );
endinterface

// File: rtl/dist_ram_dp_sync.sv
// Dual-port distributed RAM, registered outputs, byte-enable writes.
// Port A read/write, port B read-only. After reset an optional clear
// engine zeroes every word (one word per clock) while busy is high.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (outputs, FSM, sweep counter;
//          array contents are only touched by the sweep)
//   bus  : dist_ram_dp_sync_if.slave (see interface header)
module dist_ram_dp_sync #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 6,
  parameter int                    RDW_MODE       = 0,
  parameter logic [DATA_WIDTH-1:0] SRST_VAL       = '0,
  parameter int                    CLEAR_ON_RESET = 1
) (
  input logic                clk,
  input logic                rst,
  dist_ram_dp_sync_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;
  logic                  busy;
  logic                  user_we;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  // ---------------- clear controller ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      // Last word written on this edge: leave the sweep, park the counter.
      if (cnt_q == ADDR_WIDTH'(DEPTH-1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign bus.busy = busy;
  assign user_we  = bus.we & ~busy;

  // ---------------- byte-merged write word ----------------
  // Disabled bytes take the current word, so be=0 rewrites the old value.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wr_word[8*i +: 8] = bus.be[i] ? bus.d[8*i +: 8] : mem[bus.a][8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (clr_we)       mem[cnt_q] <= '0;
    else if (user_we) mem[bus.a] <= wr_word;
  end

  // ---------------- read-during-write selection ----------------
  // Write-first mode forwards the merged word on an address hit; read-first
  // simply reads the array, which still holds the pre-write word this cycle.
  always_comb begin
    rd_a = mem[bus.a];
    rd_b = mem[bus.dpra];
    if (RDW_MODE != 0 && user_we) begin
      rd_a = wr_word;
      if (bus.dpra == bus.a) rd_b = wr_word;
    end
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.qspo <= '0;
      bus.qdpo <= '0;
    end else if (busy) begin
      bus.qspo <= '0;
      bus.qdpo <= '0;
    end else begin
      if (bus.qspo_srst)    bus.qspo <= SRST_VAL;
      else if (bus.qspo_ce) bus.qspo <= rd_a;
      if (bus.qdpo_srst)    bus.qdpo <= SRST_VAL;
      else if (bus.qdpo_ce) bus.qdpo <= rd_b;
    end
  end

endmodule

// File: doc/dist_ram_dp_sync.md
# dist_ram_dp_sync

Parametrised dual-port distributed RAM with registered outputs, byte-enable writes and a selectable read-during-write mode. Port A is read/write; port B is read-only. A hardware clear engine zeroes the whole array after reset. It is the general-purpose register-file and scratch memory for the core and replaces the fixed 64x32 single-port synchronous RAM.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words
- RDW_MODE, 0, read-during-write on the same address: 0 = read-first (old data), 1 = write-first (new merged data)
- SRST_VAL, 0, value loaded into an output register by its synchronous reset
- CLEAR_ON_RESET, 1, 1 = sweep the array to zero after reset; 0 = no sweep, busy stays 0

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- a  in  ADDR_WIDTH  port A address (write and read)
- d  in  DATA_WIDTH  port A write data
- we  in  1  port A write enable
- be  in  DATA_WIDTH/8  byte enables; be[i] enables d[8i+7:8i]
- dpra  in  ADDR_WIDTH  port B read address
- qspo_ce  in  1  port A output register clock enable
- qspo_srst  in  1  port A output register synchronous reset
- qdpo_ce  in  1  port B output register clock enable
- qdpo_srst  in  1  port B output register synchronous reset
- qspo  out  DATA_WIDTH  port A registered read data
- qdpo  out  DATA_WIDTH  port B registered read data
- busy  out  1  clear sweep in progress

## Operation
- Controller FSM: CLEAR and IDLE. rst forces CLEAR if CLEAR_ON_RESET=1, else IDLE. Clear counter resets to 0.
- CLEAR: each edge writes 0 to mem[cnt], then cnt+1. The edge that writes DEPTH-1 moves the FSM to IDLE. The counter does not wrap into a second pass.
- While busy:
  - user writes are ignored
  - qspo and qdpo load 0
  - ce and srst are ignored
- IDLE write: when we=1, each byte i with be[i]=1 takes d's byte i at mem[a]. Other bytes keep their value. we=1 with be=0 changes nothing.
- Port A output register, in priority order:
  - qspo_srst=1: load SRST_VAL
  - else qspo_ce=1: load rd(a)
  - else: hold
- Port B output register, same priority: qdpo_srst, then qdpo_ce loading rd(dpra), then hold.
- rd(x) when a write targets x in the same cycle:
  - RDW_MODE=0: the pre-write word
  - RDW_MODE=1: the byte-merged post-write word
  - applies to both ports
- Memory contents are not affected by rst except through the sweep. Without the sweep, contents are undefined after power-up.

## Timing
- Reset values (asynchronous): qspo=0, qdpo=0, busy=CLEAR_ON_RESET, FSM state = CLEAR or IDLE, cnt=0.
- Write latency: data is visible to a read issued on the next edge; same edge depends on RDW_MODE.
- Read latency: 1 cycle. Address and ce are sampled at edge N; data appears on q* after edge N.
- Sweep duration: busy is high for exactly DEPTH rising edges after rst deasserts and falls at the edge that writes DEPTH-1. The first user write is accepted on the next edge.
- rst asserted mid-sweep or mid-operation: the sweep restarts from address 0. Writes already completed persist.
- srst and ce asserted together: srst wins.
- Port A and port B on the same address: both return identical data in the same cycle.
- Address wrap: a=DEPTH-1 is a normal address; no out-of-range case exists.

## Test plan
- Clear sweep (ADDR_WIDTH=6): pulse rst, then count edges with busy=1 -> exactly 64. Read all 64 addresses on port B -> all 0.
- Fill and read: write mem[i]=i for i=0..63 with be=all-ones. Read back on port A with qspo_ce=1, one cycle per address -> qspo=i one cycle after each address is presented.
- Byte enables: write 32'hAABBCCDD to address 5, then write 32'h11223344 to address 5 with be=4'b0101 -> mem[5]=32'hAA22CC44.
- Read-during-write: mem[2]=32'h10. Write 32'h22 to address 2 with qspo_ce=1 and dpra=2 -> qspo=qdpo=32'h10 for RDW_MODE=0, 32'h22 for RDW_MODE=1.
- Output control: qspo_srst=1 with qspo_ce=1 -> qspo=SRST_VAL. qspo_ce=0 with a changing -> qspo holds. During busy, writes with we=1 -> memory stays 0.
- Reset mid-sweep: assert rst at sweep edge 20 -> busy stays high and the sweep restarts at 0, taking 64 more edges. Reset mid-operation -> qspo=qdpo=0 immediately (asynchronous).
